// File: rtl/tick_stopwatch_pkg.sv
// Shared definitions for the tick stopwatch: state encoding, BCD digit limits
// and digit ordering.
package tick_stopwatch_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   localparam logic [3:0] BCD_MAX_ONES = 4'd9;
   localparam logic [3:0] BCD_MAX_TENS = 4'd5;

   localparam int N_DIGITS     = 4;
   localparam int DIG_SEC_TENS = 1;

   typedef struct packed {
      logic [3:0] min_tens;
      logic [3:0] min_ones;
      logic [3:0] sec_tens;
      logic [3:0] sec_ones;
   } bcd_time_t;

   // Only the seconds-tens digit rolls over at 5; every other digit is decimal.
   function automatic logic [3:0] digit_limit(input int idx);
      return (idx == DIG_SEC_TENS) ? BCD_MAX_TENS : BCD_MAX_ONES;
   endfunction

endpackage

// File: rtl/tick_stopwatch_bcd_digit.sv
// One BCD counter digit: clear has priority, increments roll over to zero at
// the supplied maximum and raise a carry into the next digit.
module bcd_digit #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   input  logic         i_clr,
   input  logic [W-1:0] i_max,
   output logic [W-1:0] o_value,
   output logic         o_carry
);

   logic [W-1:0] r_value;
   logic         w_at_max;

   // Treat anything at or above the limit as the rollover point so the digit
   // can never step into a non-BCD code.
   assign w_at_max = (r_value >= i_max);
   assign o_carry  = i_inc & w_at_max;
   assign o_value  = r_value;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_value <= '0;
      end else if (i_clr) begin
         r_value <= '0;
      end else if (i_inc) begin
         r_value <= w_at_max ? '0 : r_value + 1'b1;
      end
   end

endmodule

// File: rtl/tick_stopwatch.sv
// MM:SS stopwatch advanced by rising edges of a 1 Hz tick, with start/stop/clear
// controls and a one-cycle pulse when the count wraps back to 00:00.
module tick_stopwatch
   import tick_stopwatch_pkg::*;
#(
   parameter int MAX_MIN = 99
) (
   input  logic       CLK_in,
   input  logic       RST_n,
   input  logic       TICK_in,
   input  logic       START,
   input  logic       STOP,
   input  logic       CLEAR,
   output logic [3:0] SEC_ONES,
   output logic [2:0] SEC_TENS,
   output logic [3:0] MIN_ONES,
   output logic [3:0] MIN_TENS,
   output logic       RUNNING,
   output logic       WRAP
);

   localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MIN / 10);
   localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MIN % 10);

   logic              r_tick_d;
   logic              r_state;
   logic              r_wrap;

   logic              w_tick_ev;
   logic              w_count;
   logic              w_min_at_max;
   logic              w_wrap_ev;
   logic              w_clr;
   logic [N_DIGITS:0] w_inc;
   logic [3:0]        w_val [N_DIGITS];
   bcd_time_t         w_time;
   logic              w_unused;

   assign w_tick_ev = TICK_in & ~r_tick_d;
   // A tick is judged against the state before this edge, so a tick coinciding
   // with START is dropped and one coinciding with STOP still counts.
   assign w_count   = (r_state == ST_RUN) & w_tick_ev;
   assign w_inc[0]  = w_count;

   generate
      for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
         bcd_digit #(
            .W(4)
         ) u_digit (
            .i_clk   (CLK_in),
            .i_rst_n (RST_n),
            .i_inc   (w_inc[gi]),
            .i_clr   (w_clr),
            .i_max   (digit_limit(gi)),
            .o_value (w_val[gi]),
            .o_carry (w_inc[gi+1])
         );
      end
   endgenerate

   assign w_time = {w_val[3], w_val[2], w_val[1], w_val[0]};

   assign w_min_at_max = (w_time.min_tens == MAX_MIN_TENS) &&
                         (w_time.min_ones == MAX_MIN_ONES);
   // w_inc[2] is the seconds carry (xx:59 plus a counted tick); an overflow
   // out of the minutes-tens digit is also folded into the wrap.
   assign w_wrap_ev = (w_inc[2] & w_min_at_max) | w_inc[N_DIGITS];
   assign w_clr     = CLEAR | w_wrap_ev;

   always_ff @(posedge CLK_in or negedge RST_n) begin
      if (!RST_n) begin
         r_tick_d <= 1'b1;
         r_state  <= ST_IDLE;
         r_wrap   <= 1'b0;
      end else begin
         r_tick_d <= TICK_in;
         if (STOP) begin
            r_state <= ST_IDLE;
         end else if (START) begin
            r_state <= ST_RUN;
         end
         r_wrap <= w_wrap_ev & ~CLEAR;
      end
   end

   assign SEC_ONES = w_time.sec_ones;
   assign SEC_TENS = w_time.sec_tens[2:0];
   assign MIN_ONES = w_time.min_ones;
   assign MIN_TENS = w_time.min_tens;
   assign RUNNING  = (r_state == ST_RUN);
   assign WRAP     = r_wrap;

   // Seconds-tens never exceeds 5, so its top bit carries no information.
   assign w_unused = w_time.sec_tens[3];

endmodule

// File: tb/tb_tick_stopwatch.sv
// Randomized and directed bench for tick_stopwatch against a total-seconds
// reference model.
module tb_tick_stopwatch;

   localparam int MAX_MIN  = 99;
   localparam int PERIOD_S = (MAX_MIN + 1) * 60;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick  = 1'b1;
   logic       start = 1'b0;
   logic       stop  = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] sec_ones;
   logic [2:0] sec_tens;
   logic [3:0] min_ones;
   logic [3:0] min_tens;
   logic       running;
   logic       wrap;

   int m_total;
   bit m_run;
   bit m_tick_d;
   bit m_wrap;
   int n_vec = 0;
   int n_err = 0;

   tick_stopwatch #(
      .MAX_MIN(MAX_MIN)
   ) dut (
      .CLK_in   (clk),
      .RST_n    (rst_n),
      .TICK_in  (tick),
      .START    (start),
      .STOP     (stop),
      .CLEAR    (clear),
      .SEC_ONES (sec_ones),
      .SEC_TENS (sec_tens),
      .MIN_ONES (min_ones),
      .MIN_TENS (min_tens),
      .RUNNING  (running),
      .WRAP     (wrap)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_bcd(input int total);
      int s;
      int m;
      s = total % 60;
      m = total / 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [15:0] dut_bcd();
      return {min_tens, min_ones, 1'b0, sec_tens, sec_ones};
   endfunction

   task automatic model_reset();
      m_total  = 0;
      m_run    = 1'b0;
      m_tick_d = 1'b1;
      m_wrap   = 1'b0;
   endtask

   task automatic model_edge();
      bit ev;
      ev     = tick && !m_tick_d;
      m_wrap = 1'b0;
      if (clear) begin
         m_total = 0;
      end else if (m_run && ev) begin
         m_total = (m_total + 1) % PERIOD_S;
         m_wrap  = (m_total == 0);
      end
      if (stop) m_run = 1'b0;
      else if (start) m_run = 1'b1;
      m_tick_d = tick;
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, ".time"}, 32'(dut_bcd()), 32'(exp_bcd(m_total)));
      check_val({tag, ".run"}, 32'(running), 32'(m_run));
      check_val({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_edge();
      #1;
      check_outputs(tag);
   endtask

   task automatic tick_pulse(input string tag);
      tick = 1'b0;
      step(tag);
      tick = 1'b1;
      step(tag);
   endtask

   initial begin
      model_reset();
      rst_n = 1'b0;
      tick  = 1'b1;
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset");

      // Release with TICK_in already high: starts running but must not count.
      rst_n = 1'b1;
      step("release");
      repeat (3) step("hold_high");

      repeat (10) tick_pulse("count10");
      check_val("sec_is_10", 32'({sec_tens, sec_ones}), 32'h10);

      for (int i = 0; i < 3000; i++) begin
         start = ($urandom_range(0, 7) == 0);
         stop  = ($urandom_range(0, 15) == 0);
         clear = ($urandom_range(0, 31) == 0);
         tick  = 1'($urandom_range(0, 1));
         step("rand");
      end

      // START+STOP together while running: tick that cycle counts, later ones do not.
      start = 1'b1; stop = 1'b0; clear = 1'b0; tick = 1'b0;
      step("to_run");
      step("to_run");
      tick = 1'b1; stop = 1'b1;
      step("both");
      check_val("both_running", 32'(running), 32'd0);
      start = 1'b0; stop = 1'b0;
      repeat (3) tick_pulse("ignored");

      clear = 1'b1;
      step("clear");
      clear = 1'b0; start = 1'b1;
      step("restart");
      repeat (9) tick_pulse("to_09");
      check_val("at_09", 32'(dut_bcd()), 32'h0009);
      tick = 1'b0;
      step("clr_low");
      tick = 1'b1; clear = 1'b1;
      step("clr_tick");
      check_val("clr_zero", 32'(dut_bcd()), 32'h0000);
      check_val("clr_running", 32'(running), 32'd1);
      check_val("clr_wrap", 32'(wrap), 32'd0);
      clear = 1'b0;

      repeat (PERIOD_S - 1) tick_pulse("to_max");
      check_val("at_max", 32'(dut_bcd()), 32'h9959);
      tick = 1'b0;
      step("wrap_low");
      tick = 1'b1;
      step("wrap");
      check_val("wrap_pulse", 32'(wrap), 32'd1);
      check_val("wrap_zero", 32'(dut_bcd()), 32'h0000);
      step("wrap_end");
      check_val("wrap_width", 32'(wrap), 32'd0);

      clear = 1'b1;
      step("clear2");
      clear = 1'b0;
      repeat (754) tick_pulse("to_1234");
      check_val("at_1234", 32'(dut_bcd()), 32'h1234);
      start = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async");
      check_val("async_zero", 32'(dut_bcd()), 32'h0000);
      check_val("async_idle", 32'(running), 32'd0);
      #1;
      rst_n = 1'b1;
      step("post_async");
      tick_pulse("post_async_idle");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tick_stopwatch.md
TICK_STOPWATCH -- requirements
Module: tick_stopwatch

Interface
REQ-001 Parameter MAX_MIN, default 99, SHALL set the highest minute value before wrap (legal range 1..99).
REQ-002 CLK_in  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RST_n  input  1  reset, asynchronous and active-low; all state SHALL be cleared while low.
REQ-004 TICK_in  input  1  1 Hz square wave generated from CLK_in by the divider stage; synchronous to CLK_in, no synchroniser.
REQ-005 START  input  1  level, sampled each cycle; requests counting.
REQ-006 STOP  input  1  level, sampled each cycle; requests pause.
REQ-007 CLEAR  input  1  level, sampled each cycle; zeroes the count.
REQ-008 SEC_ONES  output  4  BCD seconds units, 0..9.
REQ-009 SEC_TENS  output  3  BCD seconds tens, 0..5.
REQ-010 MIN_ONES  output  4  BCD minutes units, 0..9.
REQ-011 MIN_TENS  output  4  BCD minutes tens, 0..9.
REQ-012 RUNNING  output  1  high while the state is RUN.
REQ-013 WRAP  output  1  one-cycle pulse when the count wraps to 00:00.

Function
REQ-014 The block SHALL register TICK_in into TICK_d each cycle; a tick event SHALL be the cycle where TICK_in=1 and TICK_d=0.
REQ-015 The state machine SHALL have exactly two states: IDLE (paused) and RUN.
REQ-016 IDLE->RUN when START=1 and STOP=0; RUN->IDLE when STOP=1; otherwise the state SHALL be held.
REQ-017 START and STOP asserted together SHALL resolve to STOP (IDLE).
REQ-018 In RUN, each tick event SHALL advance the count by one second at the same clock edge that samples the event; output latency SHALL be one CLK_in edge after TICK_in rises.
REQ-019 A tick event in the same cycle as the IDLE->RUN transition SHALL NOT count; a tick event in the same cycle as a RUN->IDLE transition SHALL count.
REQ-020 Carries: SEC_ONES 9->0 increments SEC_TENS; SEC_TENS 5->0 increments minutes; MIN_ONES 9->0 increments MIN_TENS.
REQ-021 At minutes = MAX_MIN and seconds = 59, the next counted tick SHALL set all digits to 0 and assert WRAP for exactly that one cycle.
REQ-022 Every digit SHALL remain within its BCD range; no non-BCD value SHALL ever be visible on an output.
REQ-023 CLEAR=1 SHALL zero all digits on that edge, override any simultaneous tick, suppress WRAP, and leave the state unchanged.
REQ-024 In IDLE, tick events SHALL be ignored and the outputs held.
REQ-025 TICK_in held constant SHALL produce no count change.

Reset
REQ-026 While RST_n=0: state=IDLE, all digits 0, RUNNING=0, WRAP=0, TICK_d=1.
REQ-027 TICK_d resetting to 1 SHALL guarantee that a TICK_in already high at reset release does not count.
REQ-028 Reset asserted mid-count SHALL take effect immediately, without waiting for a clock edge.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE=0, RUN=1) and the BCD digit limits (9, 5).
REQ-030 One sub-module, bcd_digit, SHALL be instantiated per digit, with inc, clr, and max-value inputs and value and carry outputs.

Verification
REQ-031 Reset release with TICK_in=1, START=1 -> digits 00:00, RUNNING=1 on the next edge, and no increment until the next TICK_in rise.
REQ-032 RUN with 10 TICK_in rises -> SEC_TENS=1, SEC_ONES=0, each step one CLK_in after its rise.
REQ-033 Preload to 99:59 in RUN, then one tick -> 00:00 and a WRAP pulse exactly one cycle wide.
REQ-034 START and STOP both high while in RUN -> RUNNING=0; a tick in that same cycle is counted, and later ticks are ignored.
REQ-035 CLEAR asserted on the tick cycle at 00:09 -> 00:00, RUNNING unchanged, WRAP=0.
REQ-036 RST_n pulsed low for less than one CLK_in period at 12:34 -> outputs go to 00:00 and IDLE asynchronously.
